// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encodings, the NOP instruction word
// and the sequential PC increment.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT      = 2'd0,
    FETCH_RUN       = 2'd1,
    FETCH_HOLD      = 2'd2,
    FETCH_HOLD_PEND = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INCR  = 32'd4;

  // Sequential successor of an instruction address; wraps modulo 2^32.
  function automatic logic [31:0] seq_next(input logic [31:0] addr);
    return addr + PC_INCR;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Signal bundle between the fetch unit and its surroundings (hazard unit,
// ID-stage branch resolution, instruction memory, decode stage).
// master = the environment driving controls, slave = the fetch unit.
interface fetch_pc_unit_if #(
  parameter int ADDR_W = 9
);

  // Hazard unit stalls
  logic              pc_le;
  logic              npc_le;
  logic              if_id_le;
  // ID-stage redirect
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              annul;
  // Instruction memory
  logic [31:0]       imem_instr;
  logic [ADDR_W-1:0] imem_addr;
  // Fetch state and IF/ID contents
  logic [31:0]       pc_out;
  logic [31:0]       npc_out;
  logic [31:0]       instruction_reg;
  logic [31:0]       if_id_pc;
  logic              if_id_valid;
  logic [1:0]        fetch_state;

  modport master (
    output pc_le, npc_le, if_id_le, branch_taken, branch_target, annul,
           imem_instr,
    input  imem_addr, pc_out, npc_out, instruction_reg, if_id_pc,
           if_id_valid, fetch_state
  );

  modport slave (
    input  pc_le, npc_le, if_id_le, branch_taken, branch_target, annul,
           imem_instr,
    output imem_addr, pc_out, npc_out, instruction_reg, if_id_pc,
           if_id_valid, fetch_state
  );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures the fetched word and its PC when loaded,
// or a NOP bubble when the slot is squashed.
module if_id_register #(
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,      // synchronous, active low
  input  logic        load_en,
  input  logic        squash,     // load a bubble instead of instr_in
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  // Next IF/ID contents: hold unless loaded; squashed loads become a bubble.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (load_en) begin
      // The PC is kept even for a bubble so a squashed slot stays traceable.
      pc_d = pc_in;
      if (squash) begin
        instr_d = NOP;
        valid_d = 1'b0;
      end else begin
        instr_d = instr_in;
        valid_d = 1'b1;
      end
    end
  end

  // IF/ID state register with synchronous reset to an empty NOP slot.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only (synchronous), so it is
    // tested inside the clocked block rather than in the sensitivity list.
    if (!reset) begin
      instr_q <= NOP;
      pc_q    <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC/nPC pair with delayed-branch semantics,
// stall handling from the hazard unit, a held redirect for branches that
// resolve during a stall, and the IF/ID register feeding decode.
module fetch_pc_unit #(
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset,   // synchronous, active low
  fetch_pc_unit_if.slave bus
);

  import pipeline_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  npc_q, npc_d;
  // Redirect captured while stalled; meaningful only in FETCH_HOLD_PEND,
  // which doubles as the pending flag.
  logic [31:0]  pend_target_q, pend_target_d;
  logic         booting;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH_BOOT;
    else        state_q <= state_d;
  end

  // FSM next state: one boot cycle, then run/hold with a sticky pending
  // redirect while PC is stalled.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_BOOT: state_d = FETCH_RUN;
      FETCH_RUN, FETCH_HOLD: begin
        if (bus.pc_le)             state_d = FETCH_RUN;
        else if (bus.branch_taken) state_d = FETCH_HOLD_PEND;
        else                       state_d = FETCH_HOLD;
      end
      FETCH_HOLD_PEND: begin
        if (bus.pc_le) state_d = FETCH_RUN;
      end
      default: state_d = FETCH_BOOT;
    endcase
  end

  // PC/nPC and pending-target update. nPC only moves when PC advances, and
  // npc_le can additionally hold it. In FETCH_HOLD_PEND further branches are
  // ignored so the first redirect wins.
  always_comb begin
    pc_d          = pc_q;
    npc_d         = npc_q;
    pend_target_d = pend_target_q;
    unique case (state_q)
      FETCH_RUN, FETCH_HOLD: begin
        if (bus.pc_le) begin
          pc_d = npc_q;
          if (bus.npc_le)
            npc_d = bus.branch_taken ? bus.branch_target : seq_next(npc_q);
        end else if (bus.branch_taken) begin
          pend_target_d = bus.branch_target;
        end
      end
      FETCH_HOLD_PEND: begin
        if (bus.pc_le) begin
          pc_d = npc_q;
          if (bus.npc_le) npc_d = pend_target_q;
          pend_target_d = 32'h0000_0000;
        end
      end
      default: ;  // FETCH_BOOT: PC/nPC do not advance
    endcase
  end

  // PC/nPC/pending-target registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      npc_q         <= seq_next(RESET_PC);
      pend_target_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      pend_target_q <= pend_target_d;
    end
  end

  // FSM outputs: memory address and debug state straight from registers.
  always_comb begin
    bus.imem_addr   = pc_q[ADDR_W-1:0];
    bus.pc_out      = pc_q;
    bus.npc_out     = npc_q;
    bus.fetch_state = state_q;
  end

  // The boot cycle forces a bubble into IF/ID regardless of the hazard unit.
  assign booting = (state_q == FETCH_BOOT);

  if_id_register #(
    .NOP (NOP_WORD)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .load_en   (bus.if_id_le | booting),
    .squash    (bus.annul | booting),
    .instr_in  (bus.imem_instr),
    .pc_in     (pc_q),
    .instr_out (bus.instruction_reg),
    .pc_out    (bus.if_id_pc),
    .valid_out (bus.if_id_valid)
  );

endmodule
